// File: rtl/iq_issue_ctrl.sv
// iq_issue_ctrl: head/tail/occupancy sequencer for the circular instruction queue, with flush FSM.
// Optional build macro IQ_PERF_CNT_EN adds o_starve_cnt, a saturating decode-starvation counter.
module iq_issue_ctrl #(
  parameter int ISSUEWIDTH   = 4,
  parameter int FETCHWIDTH   = 8,
  parameter int PTR_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fetch_valid,
  input  logic [3:0]       i_fetch_count,
  output logic             o_fetch_ready,
  output logic             o_wr_en,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [3:0]       o_wr_count,
  input  logic             i_dec_ready,
  output logic             o_issue_valid,
  output logic [2:0]       o_issue_count,
  output logic [PTR_W-1:0] o_rd_ptr,
  input  logic             i_flush,
  output logic [PTR_W:0]   o_occupancy,
  output logic             o_empty,
  output logic             o_full
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [15:0]      o_starve_cnt
`endif
);
  localparam int DEPTH = 2**PTR_W;
  localparam int OCC_W = PTR_W + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [PTR_W-1:0] head, tail;
  logic [OCC_W-1:0] occ, occ_nxt, room;
  logic [FC_W-1:0]  fcnt;
  logic             cnt_legal, wr_fire, iss_fire;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (wr_fire) state_nxt = RUN;
        RUN:     if ((occ_nxt == '0) && !wr_fire) state_nxt = IDLE;
        FLUSH:   if (fcnt == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs and fire terms; ready depends only on registered state
  always_comb begin
    room          = OCC_W'(DEPTH) - occ;
    cnt_legal     = (i_fetch_count != 4'd0) && (i_fetch_count <= 4'(FETCHWIDTH));
    o_fetch_ready = (room >= OCC_W'(FETCHWIDTH)) && (state != FLUSH);
    o_wr_en       = i_fetch_valid && o_fetch_ready && cnt_legal && !i_flush;
    o_wr_count    = o_wr_en ? i_fetch_count : 4'd0;
    o_wr_ptr      = tail;
    o_issue_valid = (occ != '0) && (state == RUN);
    if (!o_issue_valid)
      o_issue_count = 3'd0;
    else if (occ >= OCC_W'(ISSUEWIDTH))
      o_issue_count = 3'(ISSUEWIDTH);
    else
      o_issue_count = 3'(occ);
    o_rd_ptr      = head;
    o_occupancy   = occ;
    o_empty       = (occ == '0);
    o_full        = (occ == OCC_W'(DEPTH));
    wr_fire       = o_wr_en;
    iss_fire      = o_issue_valid && i_dec_ready;
    occ_nxt       = occ + OCC_W'(o_wr_count) - OCC_W'(iss_fire ? o_issue_count : 3'd0);
  end

  // Pointer / occupancy / flush-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      fcnt <= '0;
    end else if (i_flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      fcnt <= FC_W'(FLUSH_CYCLES - 1);
    end else begin
      if (wr_fire)  tail <= tail + PTR_W'(o_wr_count);
      if (iss_fire) head <= head + PTR_W'(o_issue_count);
      occ <= occ_nxt;
      if ((state == FLUSH) && (fcnt != '0)) fcnt <= fcnt - FC_W'(1);
    end
  end

`ifdef IQ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      o_starve_cnt <= '0;
    else if ((state != FLUSH) && (occ == '0) && i_dec_ready)
      o_starve_cnt <= sat_inc16(o_starve_cnt);
  end
`endif

endmodule

// File: tb/tb_iq_issue_ctrl.sv
// Self-checking bench for iq_issue_ctrl: queue-based reference model, directed scenarios, random traffic.
`timescale 1ns/1ps
module tb_iq_issue_ctrl;
  localparam int ISSUEWIDTH   = 4;
  localparam int FETCHWIDTH   = 8;
  localparam int PTR_W        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int DEPTH        = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_fetch_valid = 1'b0;
  logic [3:0]       i_fetch_count = 4'd0;
  logic             o_fetch_ready;
  logic             o_wr_en;
  logic [PTR_W-1:0] o_wr_ptr;
  logic [3:0]       o_wr_count;
  logic             i_dec_ready = 1'b0;
  logic             o_issue_valid;
  logic [2:0]       o_issue_count;
  logic [PTR_W-1:0] o_rd_ptr;
  logic             i_flush = 1'b0;
  logic [PTR_W:0]   o_occupancy;
  logic             o_empty;
  logic             o_full;
`ifdef IQ_PERF_CNT_EN
  logic [15:0]      o_starve_cnt;
`endif

  always #5 clk = ~clk;

  iq_issue_ctrl #(
    .ISSUEWIDTH(ISSUEWIDTH), .FETCHWIDTH(FETCHWIDTH), .PTR_W(PTR_W), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .i_fetch_valid(i_fetch_valid), .i_fetch_count(i_fetch_count), .o_fetch_ready(o_fetch_ready),
    .o_wr_en(o_wr_en), .o_wr_ptr(o_wr_ptr), .o_wr_count(o_wr_count),
    .i_dec_ready(i_dec_ready), .o_issue_valid(o_issue_valid), .o_issue_count(o_issue_count),
    .o_rd_ptr(o_rd_ptr), .i_flush(i_flush), .o_occupancy(o_occupancy),
    .o_empty(o_empty), .o_full(o_full)
`ifdef IQ_PERF_CNT_EN
    , .o_starve_cnt(o_starve_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of instruction tags plus wrap-around pointers
  int mq[$];
  int m_head = 0, m_tail = 0, m_flush_left = 0, m_seq = 0, m_starve = 0;

  function automatic bit m_flushing();
    return m_flush_left > 0;
  endfunction
  function automatic bit m_ready();
    return ((DEPTH - mq.size()) >= FETCHWIDTH) && !m_flushing();
  endfunction
  function automatic bit m_wr();
    return i_fetch_valid && m_ready() && (i_fetch_count >= 1) &&
           (i_fetch_count <= FETCHWIDTH) && !i_flush;
  endfunction
  function automatic bit m_ivalid();
    return (mq.size() != 0) && !m_flushing();
  endfunction
  function automatic int m_icnt();
    return (mq.size() < ISSUEWIDTH) ? mq.size() : ISSUEWIDTH;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_head = 0; m_tail = 0; m_flush_left = 0; m_starve = 0;
  endtask

  task automatic m_step();
    bit wr, iss;
    int ic, wc;
    wr  = m_wr();
    iss = m_ivalid() && i_dec_ready;
    ic  = m_icnt();
    wc  = int'(i_fetch_count);
    if (!m_flushing() && (mq.size() == 0) && i_dec_ready && (m_starve < 65535)) m_starve++;
    if (i_flush) begin
      mq.delete();
      m_head = 0; m_tail = 0; m_flush_left = FLUSH_CYCLES;
    end else begin
      if (m_flush_left > 0) m_flush_left--;
      if (iss) begin
        for (int k = 0; k < ic; k++) void'(mq.pop_front());
        m_head = (m_head + ic) % DEPTH;
      end
      if (wr) begin
        for (int k = 0; k < wc; k++) begin mq.push_back(m_seq); m_seq++; end
        m_tail = (m_tail + wc) % DEPTH;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) m_reset();
    else      m_step();
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("fetch_ready", o_fetch_ready, m_ready());
      check("wr_en", o_wr_en, m_wr());
      if (m_wr()) check("wr_count", o_wr_count, i_fetch_count);
      check("wr_ptr", o_wr_ptr, m_tail);
      check("issue_valid", o_issue_valid, m_ivalid());
      if (m_ivalid()) check("issue_count", o_issue_count, m_icnt());
      check("rd_ptr", o_rd_ptr, m_head);
      check("occupancy", o_occupancy, mq.size());
      check("empty", o_empty, mq.size() == 0);
      check("full", o_full, mq.size() == DEPTH);
`ifdef IQ_PERF_CNT_EN
      check("starve_cnt", o_starve_cnt, m_starve);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetch_ready", o_fetch_ready, 1);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_issue_valid", o_issue_valid, 0);
    check("rst_issue_count", o_issue_count, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_occ", o_occupancy, 0);
    rst = 1'b1;
    m_reset();
    chk_en = 1'b1;

    // Fill to 8 then 16 with decode stalled
    i_fetch_valid = 1; i_fetch_count = 8; #1;
    check("first_wr_en", o_wr_en, 1);
    cyc(); i_fetch_valid = 0; #1;
    check("occ_after_8", o_occupancy, 8);
    check("iv_after_8", o_issue_valid, 1);
    check("ic_after_8", o_issue_count, 4);
    check("wr_ptr_after_8", o_wr_ptr, 8);
    check("ready_after_8", o_fetch_ready, 1);
    i_fetch_valid = 1; i_fetch_count = 8;
    cyc(); i_fetch_valid = 0; #1;
    check("occ_full", o_occupancy, 16);
    check("full_flag", o_full, 1);
    check("ready_when_full", o_fetch_ready, 0);
    i_dec_ready = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("occ_drain", o_occupancy, 12 - 4 * k);
      check("rd_ptr_drain", o_rd_ptr, (4 + 4 * k) % 16);
    end
    check("drained_iv", o_issue_valid, 0);
    check("drained_empty", o_empty, 1);
    i_dec_ready = 0;

    // Simultaneous write and issue at occupancy 3
    i_fetch_valid = 1; i_fetch_count = 3;
    cyc(); i_fetch_valid = 0; #1;
    check("occ_3", o_occupancy, 3);
    i_fetch_valid = 1; i_fetch_count = 5; i_dec_ready = 1; #1;
    check("ic_at_3", o_issue_count, 3);
    cyc(); i_fetch_valid = 0; i_dec_ready = 0; #1;
    check("occ_after_mix", o_occupancy, 5);
    check("ic_after_mix", o_issue_count, 4);

    // Flush beats concurrent fetch and issue
    i_fetch_valid = 1; i_fetch_count = 1;
    cyc(); i_fetch_valid = 0; #1;
    check("occ_6", o_occupancy, 6);
    i_flush = 1; i_fetch_valid = 1; i_fetch_count = 4; i_dec_ready = 1;
    cyc(); i_flush = 0; i_fetch_valid = 0; #1;
    check("flush_occ", o_occupancy, 0);
    check("flush_rd_ptr", o_rd_ptr, 0);
    check("flush_wr_ptr", o_wr_ptr, 0);
    check("flush_ready_c1", o_fetch_ready, 0);
    check("flush_iv_c1", o_issue_valid, 0);
    cyc();
    check("flush_ready_c2", o_fetch_ready, 0);
    check("flush_iv_c2", o_issue_valid, 0);
    cyc();
    check("post_flush_ready", o_fetch_ready, 1);
    i_dec_ready = 0;

    // Asynchronous reset mid-run at occupancy 10
    i_fetch_valid = 1; i_fetch_count = 8;
    cyc(); i_fetch_count = 2;
    cyc(); i_fetch_valid = 0; #1;
    check("occ_10", o_occupancy, 10);
    #1 rst = 1'b0;
    m_reset();
    #1;
    check("async_occ", o_occupancy, 0);
    check("async_iv", o_issue_valid, 0);
    check("async_empty", o_empty, 1);
    cyc();
    rst = 1'b1;

`ifdef IQ_PERF_CNT_EN
    i_dec_ready = 1;
    repeat (5) cyc();
    check("starve_5", o_starve_cnt, 5);
    i_flush = 1;
    cyc(); i_flush = 0;
    check("starve_flush_entry", o_starve_cnt, 6);
    cyc(); cyc();
    check("starve_in_flush", o_starve_cnt, 6);
    i_dec_ready = 0;
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = 1'b1;
      i_fetch_valid = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 19);
      if (r == 0)      i_fetch_count = 4'd0;
      else if (r == 1) i_fetch_count = 4'($urandom_range(9, 15));
      else             i_fetch_count = 4'($urandom_range(1, 8));
      i_dec_ready = 1'($urandom_range(0, 1));
      i_flush     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        m_reset();
      end
      cyc();
    end
    rst = 1'b1;
    i_fetch_valid = 0; i_dec_ready = 0; i_flush = 0;
    cyc();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
